// File: rtl/jt49_cmdseq.sv
`default_nettype none
// ============================================================================
// Module   : jt49_cmdseq
// Brief    : Autonomous command-list player driving the jt49 write bus.
//            Fetches {op, arg} words from a synchronous command memory and
//            issues register writes, timed waits and an end marker.
// Revision : 1.0 - initial release
// ============================================================================
module jt49_cmdseq #(
  parameter int AW         = 7,
  parameter int WAIT_SHIFT = 11
) (
  input  logic          rst_n,
  input  logic          clk,
  input  logic          start,
  input  logic          abort,
  output logic [AW-1:0] cmd_addr,
  input  logic [11:0]   cmd_data,
  output logic [3:0]    addr,
  output logic [7:0]    dout,
  output logic          wr_n,
  output logic          busy,
  output logic          done
);

  localparam int CW = 8 + WAIT_SHIFT;
  localparam logic [AW-1:0] LAST_ADDR = {AW{1'b1}};

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] FETCH = 3'd1;
  localparam logic [2:0] EXEC  = 3'd2;
  localparam logic [2:0] WAITS = 3'd3;
  localparam logic [2:0] DONES = 3'd4;

  localparam logic [3:0] OP_END  = 4'hE;
  localparam logic [3:0] OP_WAIT = 4'hF;

  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [3:0]    op;
  logic [7:0]    arg;
  logic [CW-1:0] wait_len;
  logic          advance;

  assign op       = cmd_data[11:8];
  assign arg      = cmd_data[7:0];
  assign wait_len = CW'(arg) << WAIT_SHIFT;

  // Advance to the next entry after a write, a zero-length wait, or the last wait cycle
  always_comb begin
    advance = 1'b0;
    if (state == EXEC)
      advance = (op < OP_END) || ((op == OP_WAIT) && (arg == 8'd0));
    else if (state == WAITS)
      advance = (cnt == CW'(1));
  end

  // Sequencer state, command pointer, wait counter and registered jt49 bus
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cmd_addr <= '0;
      addr     <= 4'd0;
      dout     <= 8'd0;
      wr_n     <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      cnt      <= '0;
    end else begin
      // The strobe is a single-cycle pulse; it falls back high unless re-armed below
      wr_n <= 1'b1;
      if (abort) begin
        // abort wins over everything, including a write being issued this edge
        state <= IDLE;
        busy  <= 1'b0;
        done  <= 1'b0;
        cnt   <= '0;
      end else begin
        case (state)
          IDLE, DONES: begin
            if (start) begin
              cmd_addr <= '0;
              busy     <= 1'b1;
              done     <= 1'b0;
              state    <= FETCH;
            end
          end
          FETCH: state <= EXEC;
          EXEC: begin
            if (op < OP_END) begin
              addr <= op;
              dout <= arg;
              wr_n <= 1'b0;
            end else if (op == OP_WAIT) begin
              cnt <= wait_len;
              if (arg != 8'd0)
                state <= WAITS;
            end else begin
              state <= DONES;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
          WAITS: cnt <= cnt - CW'(1);
          default: state <= IDLE;
        endcase
        if (advance) begin
          // The list end terminates playback; the pointer never wraps
          if (cmd_addr == LAST_ADDR) begin
            state <= DONES;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            cmd_addr <= cmd_addr + AW'(1);
            state    <= FETCH;
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_jt49_cmdseq.sv
`default_nettype none
// ============================================================================
// Module   : tb_jt49_cmdseq
// Brief    : Self-checking bench for jt49_cmdseq with a synchronous command
//            memory model and a log of every write strobe.
// Revision : 1.0 - initial release
// ============================================================================
module tb_jt49_cmdseq;

  logic        rst_n, clk, start, abort;
  logic [6:0]  cmd_addr;
  logic [11:0] cmd_data;
  logic [3:0]  addr;
  logic [7:0]  dout;
  logic        wr_n, busy, done;

  logic [11:0] mem [0:127];
  int cyc;
  int p_cyc[$];
  int p_addr[$];
  int p_dout[$];
  int n_chk;
  int n_err;

  typedef struct {
    logic [11:0] cmd;
    int          n_wr;
    int          e_addr;
    int          e_dout;
  } vec_t;

  jt49_cmdseq #(.AW(7), .WAIT_SHIFT(11)) dut (
    .rst_n(rst_n), .clk(clk), .start(start), .abort(abort),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .addr(addr), .dout(dout), .wr_n(wr_n), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter and one-cycle-latency command memory
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    cmd_data <= mem[cmd_addr];
  end

  // Record every cycle where the strobe is low
  always @(negedge clk) begin
    if (rst_n && !wr_n) begin
      p_cyc.push_back(cyc);
      p_addr.push_back(int'(addr));
      p_dout.push_back(int'(dout));
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_log();
    p_cyc.delete();
    p_addr.delete();
    p_dout.delete();
  endtask

  task automatic fill(input logic [11:0] v);
    for (int i = 0; i < 128; i++) mem[i] = v;
  endtask

  task automatic go(output int s);
    @(negedge clk);
    start = 1'b1;
    s = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget, output int dc);
    dc = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        dc = cyc;
        return;
      end
    end
    n_chk++;
    n_err++;
    $display("FAIL %s: done not seen within %0d cycles", name, budget);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  vec_t vt[7];
  int s, dc, s2, dc2, k;
  int r1[3];

  initial begin
    cyc = 0; cmd_data = 12'h000;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    fill(12'hE00);
    vt[0] = '{12'h05A, 1, 'h0, 'h5A};
    vt[1] = '{12'h73C, 1, 'h7, 'h3C};
    vt[2] = '{12'hDFF, 1, 'hD, 'hFF};
    vt[3] = '{12'hE12, 0, 'hD, 'hFF};
    vt[4] = '{12'hF00, 0, 'hD, 'hFF};
    vt[5] = '{12'hA00, 1, 'hA, 'h00};
    vt[6] = '{12'h180, 1, 'h1, 'h80};

    idle_cycles(3);
    chk("rst cmd_addr", int'(cmd_addr), 0);
    chk("rst addr", int'(addr), 0);
    chk("rst dout", int'(dout), 0);
    chk("rst wr_n", int'(wr_n), 1);
    chk("rst busy", int'(busy), 0);
    chk("rst done", int'(done), 0);
    rst_n = 1'b1;
    idle_cycles(2);

    // Two writes then end marker
    mem[0] = 12'h001; mem[1] = 12'h100; mem[2] = 12'hEFF;
    clear_log();
    go(s);
    chk("t1 busy after start", int'(busy), 1);
    wait_done("t1", 50, dc);
    chk("t1 pulses", p_cyc.size(), 2);
    chk("t1 p0 time", p_cyc[0] - s, 3);
    chk("t1 p0 addr", p_addr[0], 0);
    chk("t1 p0 dout", p_dout[0], 'h01);
    chk("t1 gap", p_cyc[1] - p_cyc[0], 2);
    chk("t1 p1 addr", p_addr[1], 1);
    chk("t1 p1 dout", p_dout[1], 'h00);
    chk("t1 done lag", dc - p_cyc[1], 2);
    chk("t1 busy end", int'(busy), 0);
    chk("t1 addr hold", int'(addr), 1);
    r1[0] = p_cyc[0] - s; r1[1] = p_cyc[1] - s; r1[2] = dc - s;

    // Single-command table, each followed by an end marker, restarted from DONE
    for (int i = 0; i < 7; i++) begin
      fill(12'hE00);
      mem[0] = vt[i].cmd;
      clear_log();
      go(s);
      wait_done($sformatf("vec%0d", i), 50, dc);
      chk($sformatf("vec%0d pulses", i), p_cyc.size(), vt[i].n_wr);
      chk($sformatf("vec%0d addr", i), int'(addr), vt[i].e_addr);
      chk($sformatf("vec%0d dout", i), int'(dout), vt[i].e_dout);
      chk($sformatf("vec%0d busy", i), int'(busy), 0);
      chk($sformatf("vec%0d wr_n", i), int'(wr_n), 1);
    end

    // Timed wait of 2<<11 cycles then a write
    fill(12'hE00);
    mem[0] = 12'hF02; mem[1] = 12'hD0E;
    clear_log();
    go(s);
    idle_cycles(2000);
    chk("t2 busy mid wait", int'(busy), 1);
    chk("t2 no early write", p_cyc.size(), 0);
    wait_done("t2", 5000, dc);
    chk("t2 pulses", p_cyc.size(), 1);
    chk("t2 latency", p_cyc[0] - s, 4101);
    chk("t2 addr", p_addr[0], 'hD);
    chk("t2 dout", p_dout[0], 'h0E);

    // Zero-length wait between two writes
    fill(12'hE00);
    mem[0] = 12'h001; mem[1] = 12'hF00; mem[2] = 12'h205;
    clear_log();
    go(s);
    wait_done("t3", 50, dc);
    chk("t3 pulses", p_cyc.size(), 2);
    chk("t3 p0 time", p_cyc[0] - s, 3);
    chk("t3 gap", p_cyc[1] - p_cyc[0], 4);
    chk("t3 p1 addr", p_addr[1], 2);
    chk("t3 p1 dout", p_dout[1], 'h05);

    // No end marker: 128 writes then stop at the last entry
    fill(12'h80F);
    clear_log();
    go(s);
    wait_done("t4", 400, dc);
    idle_cycles(20);
    chk("t4 pulses", p_cyc.size(), 128);
    chk("t4 cmd_addr", int'(cmd_addr), 127);
    chk("t4 done", int'(done), 1);
    chk("t4 last addr", p_addr[127], 8);
    chk("t4 last dout", p_dout[127], 'h0F);
    chk("t4 last gap", p_cyc[127] - p_cyc[126], 2);

    // Abort in the middle of a wait, then restart
    fill(12'hE00);
    mem[0] = 12'hF01; mem[1] = 12'h301;
    clear_log();
    go(s);
    idle_cycles(100);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("ab busy", int'(busy), 0);
    chk("ab done", int'(done), 0);
    idle_cycles(2200);
    chk("ab no write", p_cyc.size(), 0);
    chk("ab still idle", int'(busy), 0);
    go(s);
    wait_done("ab restart", 2200, dc);
    chk("ab pulses", p_cyc.size(), 1);
    chk("ab latency", p_cyc[0] - s, 2053);
    chk("ab addr", p_addr[0], 3);

    // abort beats start in DONE
    @(negedge clk);
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("prio busy", int'(busy), 0);
    chk("prio done", int'(done), 0);

    // Reset dropped while the strobe is low
    fill(12'hE00);
    mem[0] = 12'h0AA; mem[1] = 12'h1BB;
    go(s);
    k = 0;
    while (wr_n && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("rs strobe seen", int'(wr_n), 0);
    rst_n = 1'b0;
    #1;
    chk("rs wr_n", int'(wr_n), 1);
    chk("rs busy", int'(busy), 0);
    chk("rs addr", int'(addr), 0);
    chk("rs dout", int'(dout), 0);
    chk("rs cmd_addr", int'(cmd_addr), 0);
    idle_cycles(3);
    rst_n = 1'b1;
    idle_cycles(2);
    clear_log();
    go(s);
    wait_done("rs replay", 50, dc);
    chk("rs pulses", p_cyc.size(), 2);
    chk("rs p0 dout", p_dout[0], 'hAA);
    chk("rs p1 dout", p_dout[1], 'hBB);

    // start while busy ignored; start in DONE gives identical replay
    fill(12'hE00);
    mem[0] = 12'h001; mem[1] = 12'h100; mem[2] = 12'hEFF;
    clear_log();
    go(s);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("sb", 50, dc);
    chk("sb pulses", p_cyc.size(), 2);
    chk("sb p0", p_cyc[0] - s, r1[0]);
    chk("sb p1", p_cyc[1] - s, r1[1]);
    chk("sb done", dc - s, r1[2]);
    clear_log();
    go(s2);
    wait_done("rp", 50, dc2);
    chk("rp pulses", p_cyc.size(), 2);
    chk("rp p0", p_cyc[0] - s2, 3);
    chk("rp p1", p_cyc[1] - s2, 5);
    chk("rp done", dc2 - s2, 7);
    chk("rp p1 addr", p_addr[1], 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/jt49_cmdseq.md
Name: jt49_cmdseq

Overview:
- Autonomous register-write sequencer that sits directly upstream of jt49 and drives its write bus (addr, din, wr_n).
- Fetches 12-bit commands {op[3:0], arg[7:0]} from an external synchronous command memory.
- Issues PSG register writes, timed waits, and an end marker.
- Plays scripted tune/test sequences without a CPU.

Parameters:
- AW, 7, command memory address width; list length is 2**AW entries.
- WAIT_SHIFT, 11, a wait command lasts arg<<WAIT_SHIFT clk cycles.

Ports:
- rst_n      input   1            asynchronous active-low reset
- clk        input   1            clock, all logic on rising edge
- start      input   1            start playback from entry 0; sampled in IDLE or DONE only
- abort      input   1            synchronous stop; return to IDLE
- cmd_addr   output  AW           command memory read address
- cmd_data   input   12           command memory data, valid one cycle after cmd_addr changes
- addr       output  4            jt49 register address
- dout       output  8            jt49 write data
- wr_n       output  1            jt49 write strobe, active low
- busy       output  1            high while in FETCH, EXEC or WAIT
- done       output  1            high in DONE

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - cmd_addr=0, addr=0, dout=0, wr_n=1, busy=0, done=0, wait counter=0.
- All outputs are registered.
- Wait counter is 8+WAIT_SHIFT bits wide, unsigned, no overflow possible.
- States: IDLE, FETCH, EXEC, WAIT, DONE.
- IDLE: start=1 -> cmd_addr<=0, busy<=1, go FETCH.
- FETCH: one cycle for memory latency -> EXEC.
- EXEC decodes op=cmd_data[11:8], arg=cmd_data[7:0]:
  - op 0x0-0xD: addr<=op, dout<=arg, wr_n<=0; then ADVANCE.
  - op 0xF: cnt<=arg<<WAIT_SHIFT. If arg==0, ADVANCE immediately (zero-length wait); else go WAIT.
  - op 0xE: go DONE, busy<=0, done<=1; no write.
- WAIT: cnt decrements each cycle. When cnt==1, ADVANCE. Exactly arg<<WAIT_SHIFT cycles are spent in WAIT.
- ADVANCE (action taken in the same edge, not a state):
  - If cmd_addr == 2**AW-1: go DONE. The list end acts as an implicit end; no wrap to 0.
  - Else cmd_addr<=cmd_addr+1 and go FETCH.
- wr_n strobe:
  - Low for exactly one cycle, on the cycle after EXEC, then returns high.
  - addr and dout stay at the written value after the strobe; they change only on the next write.
  - Back-to-back write commands produce wr_n pulses 2 cycles apart.
- DONE: holds outputs, wr_n=1. start=1 -> restart exactly as from IDLE (done<=0, busy<=1, cmd_addr<=0).
- start while busy: ignored.
- abort=1 in any state:
  - Next state IDLE; busy<=0, done<=0, wr_n<=1, cnt<=0.
  - A wr_n pulse scheduled on the same edge is suppressed.
  - abort has priority over start.
- Reset mid-operation (during WAIT or the write strobe): everything returns to reset values immediately; no partial strobe remains.
- cmd_data is ignored outside EXEC.

Test Plan:
- Reset then pulse start; memory = {0x0,0x01},{0x1,0x00},{0xE,0xFF} -> wr_n low pulses 2 cycles apart with (addr=0,dout=0x01) then (addr=1,dout=0x00); done=1 two cycles after the second pulse; busy low.
- Memory {0xF,0x02},{0xD,0x0E},{0xE,..} with WAIT_SHIFT=11 -> exactly 4096 cycles in WAIT, then a write addr=0xD, dout=0x0E; cycle count from the EXEC of the wait to the wr_n pulse checked.
- Zero wait {0xF,0x00} between two writes -> no WAIT state entered; writes 4 cycles apart.
- No end marker, all 128 entries write {0x8,0x0F} with AW=7 -> 128 wr_n pulses, cmd_addr stops at 127, done=1, no 129th write.
- abort asserted mid-WAIT, then start; also rst_n dropped during a wr_n-low cycle -> IDLE, wr_n=1 immediately (async on reset); restart replays from entry 0.
- start pulsed while busy -> no effect on cmd_addr sequence; start in DONE -> full replay identical to first run.
